dsam_decoder: RTL and testbench
===============================

Name: dsam_decoder

Overview:
- Receive side of the DSAM bus-encoding link. Inverts the dsam_encoder transform.
- Takes a stream of encoded words on which CHANNELS logical channels are interleaved round-robin.
- Rebuilds each original word by XORing it with that channel's last decoded word.
- Sits between the link receive register and the consumer. Uses a valid/ready handshake, has one registered output stage and sustains full throughput.

Parameters:
- ADDR_WIDTH, 3: width of the per-channel beat counter. Each channel resyncs (sends its word raw) every 2^ADDR_WIDTH beats.
- DATA_WIDTH, 16: word width.
- CHANNELS, 4: number of interleaved channels. Legal values are 1 or more; CH_W = max(1, clog2(CHANNELS)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- resync  in  1  single-cycle pulse: restart the channel sequence and force raw mode.
- in_valid  in  1  encoded word present.
- in_ready  out  1  decoder can accept a word this cycle.
- in  in  DATA_WIDTH  encoded word.
- out_valid  out  1  decoded word present.
- out_ready  in  1  consumer accepts the word this cycle.
- out  out  DATA_WIDTH  decoded word.
- out_channel  out  CH_W  channel of the word on out.

Behaviour:
- Reset is synchronous and active-high; it is sampled on rising clk.
- Reset values: out_valid=0, out=0, out_channel=0, channel pointer ptr=0, hist[0..CHANNELS-1]=0, cnt[0..CHANNELS-1]=0. in_ready reads 1 one cycle after reset releases.
- Reset overrides everything, including resync and any handshake in the same cycle.
- in_ready = !out_valid || out_ready. This is combinational from out_ready, with no dependency on in_valid.
- A beat is accepted when in_valid && in_ready. For channel c = ptr:
  - ref = 0 when cnt[c] == 0, otherwise hist[c].
  - dec = in XOR ref.
  - Next cycle: out=dec, out_channel=c, out_valid=1, hist[c]=dec, cnt[c]=cnt[c]+1 (mod 2^ADDR_WIDTH), ptr=(c==CHANNELS-1)?0:c+1.
- Latency is exactly 1 cycle from acceptance to out_valid.
- Output handshake:
  - out_valid && out_ready with no new accept: out_valid goes to 0. out and out_channel hold their last value.
  - out_valid && !out_ready: out, out_channel and out_valid hold. in_ready=0, so ptr, hist and cnt are frozen.
  - An output handshake and an input accept in the same cycle give back-to-back streaming with no bubble.
- Resync:
  - Without an accept: ptr=0 and all cnt=0. hist is left unchanged but unused until rewritten. out and out_valid are not affected.
  - With an accept in the same cycle: the beat is decoded as the first beat after resync. It is channel 0 and raw (dec=in). Then cnt[0]=1, all other cnt=0, hist[0]=in, and ptr=1 (ptr=0 when CHANNELS=1).
  - Resync while in_ready=0: the state is still cleared and the output register holds.
- Counter wrap: when a channel's cnt returns to 0 after 2^ADDR_WIDTH beats, that channel's next beat is raw. This bounds error propagation to 2^ADDR_WIDTH beats per channel.
- CHANNELS=1: ptr is constant 0 and out_channel is always 0.

Optional Feature:
- Macro: DSAM_DECODER_BYPASS_EN.
- Defined: adds input port bypass (1 bit).
  - While bypass=1, an accepted beat gives dec=in, ignoring ref.
  - hist[c]=in; cnt and ptr still advance normally, keeping the channel sequence aligned with the encoder.
  - Handshake and latency are unchanged.
- Not defined: no bypass port; decoding always follows the ref rule.

Test Plan:
All tests use ADDR_WIDTH=3, DATA_WIDTH=16, CHANNELS=4.
1. Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, out=0x0000, out_channel=0 throughout; in_ready=1 one cycle after release.
2. Basic decode: stream in=0x0001..0x0008, one per cycle, out_ready=1 -> out (1 cycle later) = 0x0001, 0x0002, 0x0003, 0x0004, 0x0004, 0x0004, 0x0004, 0x000C; out_channel = 0, 1, 2, 3, 0, 1, 2, 3.
3. Counter wrap: send 36 beats of 0x00FF -> each channel's outputs alternate 0x00FF, 0x0000 for 8 beats. Beats 33-36 (9th beat of each channel) = 0x00FF (raw), not 0x0000.
4. Backpressure: after test 2's first 5 beats, drop out_ready for 3 cycles with in_valid=1 and in=0x0006 -> in_ready=0, out holds 0x0004 / out_channel=0, no state change. Raise out_ready -> next out=0x0004, out_channel=1, with no bubble.
5. Resync with accept: after 5 beats of test 2, pulse resync with in=0x1234 -> out=0x1234, out_channel=0. Next in=0x1235 -> out=0x1235, out_channel=1 (raw, since cnt[1]=0). Beat 5 after resync with in=0x0001 -> out=0x1235, out_channel=0.
6. With DSAM_DECODER_BYPASS_EN: bypass=1 on beats 5-8 of test 2 -> out=0x0005..0x0008. Then drop bypass and send 0x0001 -> out=0x0004 (channel 0, ref=0x0005).

Source files
------------

// File: rtl/dsam_decoder_if.sv
// DSAM decoder stream interface: encoded input stream and decoded output
// stream, each with its own valid/ready handshake.
//   in_valid / in_ready / in           : encoded words from the link receiver
//   out_valid / out_ready / out        : decoded words towards the consumer
//   out_channel                        : channel index of the word on out
// master: the side that feeds encoded words and consumes decoded ones.
// slave : the decoder itself.
interface dsam_decoder_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CH_W       = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out;
  logic [CH_W-1:0]       out_channel;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_channel
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_channel
  );
endinterface

// File: rtl/dsam_decoder.sv
// DSAM bus-encoding link, receive side. Words of CHANNELS logical channels
// arrive interleaved round-robin; each word is rebuilt by XORing it with the
// last decoded word of its channel. Every channel sends its word raw once per
// 2^ADDR_WIDTH beats so a corrupted word cannot propagate indefinitely.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   resync     : one-cycle pulse, restarts the channel sequence in raw mode
//   bypass     : (only with DSAM_DECODER_BYPASS_EN) pass accepted words through
//   bus        : dsam_decoder_if.slave, input/output valid-ready streams
// Optional feature macro: DSAM_DECODER_BYPASS_EN
module dsam_decoder #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          resync,
`ifdef DSAM_DECODER_BYPASS_EN
  input  logic          bypass,
`endif
  dsam_decoder_if.slave bus
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  // Per-channel decode state and channel pointer
  logic [CH_W-1:0]       ptr;
  logic [DATA_WIDTH-1:0] hist [CHANNELS];
  logic [ADDR_WIDTH-1:0] cnt  [CHANNELS];

  // Output register stage
  logic [DATA_WIDTH-1:0] out_q;
  logic [CH_W-1:0]       out_ch_q;
  logic                  out_valid_q;

  logic                  in_ready_c;
  logic                  accept_c;
  logic [CH_W-1:0]       cur_ch_c;
  logic [CH_W-1:0]       nxt_ch_c;
  logic [ADDR_WIDTH-1:0] cur_cnt_c;
  logic                  raw_c;
  logic [DATA_WIDTH-1:0] dec_c;

  // Decode path; a resync in the same cycle makes the beat channel 0, raw
  always_comb begin
    in_ready_c = !out_valid_q || bus.out_ready;
    accept_c   = bus.in_valid && in_ready_c;
    cur_ch_c   = resync ? '0 : ptr;
    cur_cnt_c  = resync ? '0 : cnt[cur_ch_c];
    raw_c      = (cur_cnt_c == '0);
`ifdef DSAM_DECODER_BYPASS_EN
    raw_c      = raw_c || bypass;
`endif
    dec_c      = raw_c ? bus.in : (bus.in ^ hist[cur_ch_c]);
    nxt_ch_c   = (cur_ch_c == LAST_CH) ? '0 : CH_W'(cur_ch_c + 1'b1);
  end

  // State and output register; accept overrides the resync clear of cnt[cur]
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      hist        <= '{default: '0};
      cnt         <= '{default: '0};
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (resync) begin
        ptr <= '0;
        cnt <= '{default: '0};
      end
      if (accept_c) begin
        hist[cur_ch_c] <= dec_c;
        cnt[cur_ch_c]  <= ADDR_WIDTH'(cur_cnt_c + 1'b1);
        ptr            <= nxt_ch_c;
        out_q          <= dec_c;
        out_ch_q       <= cur_ch_c;
        out_valid_q    <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out         = out_q;
  assign bus.out_channel = out_ch_q;

endmodule

// File: tb/tb_dsam_decoder.sv
// Self-checking bench for dsam_decoder: directed scenarios followed by a
// randomized phase, all compared against a per-channel behavioural model.
module tb_dsam_decoder;

  localparam int unsigned AW  = 3;
  localparam int unsigned DW  = 16;
  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;

  logic clk = 1'b0;
  logic reset;
  logic resync;
  logic bypass;

  dsam_decoder_if #(.DATA_WIDTH(DW), .CH_W(CHW)) bus ();

  dsam_decoder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CHANNELS  (NCH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .resync(resync),
`ifdef DSAM_DECODER_BYPASS_EN
    .bypass(bypass),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: beats since resync per channel, last decoded word
  int          m_beats [NCH];
  logic [DW-1:0] m_last [NCH];
  int          m_total;
  logic        m_ov;
  logic [DW-1:0] m_out;
  int          m_ch;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp2 [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NCH); i++) begin
      m_beats[i] = 0;
      m_last[i]  = '0;
    end
    m_total = 0;
    m_ov    = 1'b0;
    m_out   = '0;
    m_ch    = 0;
  endtask

  // One clock cycle with the given inputs; checks in_ready before the edge
  // and the output register after it.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy,
                      input logic rs, input logic byp);
    logic          acc;
    logic          raw;
    int            c;
    logic [DW-1:0] dec;
    bus.in_valid  = v;
    bus.in        = d;
    bus.out_ready = ordy;
    resync        = rs;
    bypass        = byp;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(!m_ov || ordy));
    acc = v && (!m_ov || ordy);
    @(posedge clk);
    #1;
    if (rs) begin
      m_total = 0;
      for (int i = 0; i < int'(NCH); i++) m_beats[i] = 0;
    end
    if (acc) begin
      c   = m_total % int'(NCH);
      raw = ((m_beats[c] % (1 << AW)) == 0) || bypass;
      dec = raw ? d : (d ^ m_last[c]);
      m_last[c] = dec;
      m_beats[c]++;
      m_total++;
      m_out = dec;
      m_ch  = c;
      m_ov  = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    check("out_valid",   32'(bus.out_valid),   32'(m_ov));
    check("out",         32'(bus.out),         32'(m_out));
    check("out_channel", 32'(bus.out_channel), 32'(m_ch));
  endtask

  task automatic do_reset(input int n);
    reset        = 1'b1;
    resync       = 1'b0;
    bus.in_valid = 1'b1;
    bus.in       = 16'hA5A5;
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("rst_out_valid",   32'(bus.out_valid),   32'd0);
      check("rst_out",         32'(bus.out),         32'd0);
      check("rst_out_channel", 32'(bus.out_channel), 32'd0);
    end
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_idle_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    resync        = 1'b0;
    bypass        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.out_ready = 1'b0;
    exp2 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
             16'h0004, 16'h0004, 16'h0004, 16'h000C};
    model_reset();

    // Reset held two cycles with in_valid high
    do_reset(2);

    // Basic decode, first five beats
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      check("t2_out", 32'(bus.out), 32'(exp2[i-1]));
      check("t2_ch",  32'(bus.out_channel), 32'((i - 1) % 4));
    end
    // Backpressure for three cycles: output and state frozen
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
      check("t4_hold_out", 32'(bus.out), 32'h0004);
      check("t4_hold_ch",  32'(bus.out_channel), 32'd0);
      check("t4_hold_vld", 32'(bus.out_valid), 32'd1);
    end
    // Release: remaining beats stream with no bubble
    for (int i = 6; i <= 8; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      check("t2_out", 32'(bus.out), 32'(exp2[i-1]));
      check("t2_ch",  32'(bus.out_channel), 32'((i - 1) % 4));
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Resync without accept, then counter wrap with constant data
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("rs_out_keep", 32'(bus.out), 32'h000C);
    for (int b = 0; b < 36; b++) begin
      step(1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0);
      check("t3_wrap", 32'(bus.out), (((b / 4) % 2) == 0) ? 32'h00FF : 32'h0000);
    end

    // Resync with accept in the same cycle
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
    check("t5_first", 32'(bus.out), 32'h1234);
    check("t5_first_ch", 32'(bus.out_channel), 32'd0);
    step(1'b1, 16'h1235, 1'b1, 1'b0, 1'b0);
    check("t5_second", 32'(bus.out), 32'h1235);
    check("t5_second_ch", 32'(bus.out_channel), 32'd1);
    step(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("t5_fifth", 32'(bus.out), 32'h1235);
    check("t5_fifth_ch", 32'(bus.out_channel), 32'd0);

`ifdef DSAM_DECODER_BYPASS_EN
    // Bypass on beats 5-8, then normal decoding against the bypassed word
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0, (i >= 5));
      if (i >= 5) check("t6_bypass", 32'(bus.out), 32'(i));
    end
    step(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("t6_after", 32'(bus.out), 32'h0004);
    check("t6_after_ch", 32'(bus.out_channel), 32'd0);
`endif

    // Randomized traffic with occasional resync and backpressure
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 6,
           $urandom_range(0, 39) == 0,
`ifdef DSAM_DECODER_BYPASS_EN
           $urandom_range(0, 7) == 0
`else
           1'b0
`endif
          );
    end

    // Mid-run reset clears everything, then a short run from scratch
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    do_reset(1);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'($urandom), $urandom_range(0, 3) != 0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
